// File: rtl/mul_iter_if.sv
// Request/response bundle for the iterative multiplier: operand request on one
// side, product response on the other, plus the pipeline flush.
interface mul_iter_if #(
    parameter int XLEN = 32
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          op;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic                out_valid;
    logic                out_ready;
    logic [2*XLEN-1:0]   product;
    logic [XLEN-1:0]     result;

    modport master (
        output flush, in_valid, op, op_a, op_b, out_ready,
        input  in_ready, out_valid, product, result
    );

    modport slave (
        input  flush, in_valid, op, op_a, op_b, out_ready,
        output in_ready, out_valid, product, result
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative sign-magnitude multiplier retiring RADIX_BITS multiplier bits per
// cycle, with optional early exit once the remaining multiplier is zero.
module mul_iter #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 2,
    parameter int EARLY_TERM = 1
) (
    input  logic       clk,
    input  logic       reset,
    mul_iter_if.slave  bus_if
);
    localparam int STEPS = XLEN / RADIX_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic                neg_q, neg_d;
    logic                low_q, low_d;
    logic [2*XLEN-1:0]   product_q, product_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                aNeg, bNeg;
    logic [XLEN-1:0]     aMag, bMag;
    logic [2*XLEN-1:0]   partial;
    logic [2*XLEN-1:0]   accNext;
    logic [2*XLEN-1:0]   prodFinal;
    logic [XLEN-1:0]     mplierNext;
    logic                lastStep;

    // Operands are reduced to magnitudes at accept; the sign is reapplied once at the end.
    always_comb begin
        aNeg = bus_if.op[0] & bus_if.op_a[XLEN-1];
        bNeg = (bus_if.op == 2'b01) & bus_if.op_b[XLEN-1];
        aMag = aNeg ? (~bus_if.op_a + 1'b1) : bus_if.op_a;
        bMag = bNeg ? (~bus_if.op_b + 1'b1) : bus_if.op_b;

        partial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end

        accNext    = acc_q + partial;
        prodFinal  = neg_q ? (~accNext + 1'b1) : accNext;
        mplierNext = mplier_q >> RADIX_BITS;
        lastStep   = (count_q == CW'(1)) ||
                     ((EARLY_TERM != 0) && (mplierNext == '0));
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        low_d     = low_q;
        product_d = product_q;
        result_d  = result_q;

        if (bus_if.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_if.in_valid) begin
                        mcand_d  = {{XLEN{1'b0}}, aMag};
                        mplier_d = bMag;
                        acc_d    = '0;
                        count_d  = CW'(STEPS);
                        neg_d    = aNeg ^ bNeg;
                        low_d    = (bus_if.op == 2'b00);
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    acc_d    = accNext;
                    mcand_d  = mcand_q << RADIX_BITS;
                    mplier_d = mplierNext;
                    count_d  = count_q - CW'(1);
                    if (lastStep) begin
                        product_d = prodFinal;
                        result_d  = low_q ? prodFinal[XLEN-1:0]
                                          : prodFinal[2*XLEN-1:XLEN];
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (bus_if.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            low_q     <= 1'b0;
            product_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            low_q     <= low_d;
            product_q <= product_d;
            result_q  <= result_d;
        end
    end

    assign bus_if.in_ready  = (state_q == IDLE);
    assign bus_if.out_valid = (state_q == DONE);
    assign bus_if.product   = product_q;
    assign bus_if.result    = result_q;

endmodule
